// File: rtl/rf_cmd_seq.sv
// Command sequencer feeding the register file: expands host WRITE/FILL/CLEAR/INCR
// commands into single-register writes and returns a count/error response.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// WRITE | issuing register-file writes, one per cycle
// RESP  | holding the response until rsp_ready
module rf_cmd_seq #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W:0]   cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W:0]   rsp_count,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] rf_addr,
    output logic              rf_wren,
    output logic [DATA_W:0]   rf_data,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WRITE, RESP} state_t;

    localparam logic [1:0]      OP_WRITE = 2'd0;
    localparam logic [1:0]      OP_FILL  = 2'd1;
    localparam logic [1:0]      OP_CLEAR = 2'd2;
    localparam logic [1:0]      OP_INCR  = 2'd3;
    localparam logic [ADDR_W:0] NUM_REGS = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [DATA_W-1:0]   cur_data_q, cur_data_d;
    logic [ADDR_W:0]     remaining_q, remaining_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                incr_q, incr_d;
    logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0]   rf_data_q, rf_data_d;
    logic                rf_wren_q, rf_wren_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [ADDR_W:0]     rsp_count_q, rsp_count_d;
    logic                rsp_err_q, rsp_err_d;

    logic                len_op;
    logic                illegal;
    logic [ADDR_W:0]     len_eff;
    logic [ADDR_W-1:0]   first_addr;
    logic [DATA_W-1:0]   first_data;

    always_comb begin
        len_op     = (cmd_op == OP_FILL) || (cmd_op == OP_INCR);
        illegal    = len_op && ((cmd_len == '0) || (cmd_len > NUM_REGS));
        first_addr = (cmd_op == OP_CLEAR) ? '0 : cmd_addr;
        first_data = (cmd_op == OP_CLEAR) ? '0 : cmd_data;
        case (cmd_op)
            OP_WRITE: len_eff = (ADDR_W+1)'(1);
            OP_CLEAR: len_eff = NUM_REGS;
            default:  len_eff = cmd_len;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        cur_data_d  = cur_data_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        incr_d      = incr_q;
        rf_addr_d   = rf_addr_q;
        rf_data_d   = rf_data_q;
        rf_wren_d   = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_count_d = rsp_count_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (illegal) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_count_d = '0;
                    end else begin
                        // First write is registered at acceptance so it lands one edge later.
                        state_d     = WRITE;
                        incr_d      = (cmd_op == OP_INCR);
                        rf_wren_d   = 1'b1;
                        rf_addr_d   = first_addr;
                        rf_data_d   = first_data;
                        cur_addr_d  = first_addr + ADDR_W'(1);
                        cur_data_d  = (cmd_op == OP_INCR) ? first_data + DATA_W'(1) : first_data;
                        remaining_d = len_eff - (ADDR_W+1)'(1);
                        count_d     = len_eff;
                    end
                end
            end
            WRITE: begin
                if (remaining_q == '0) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_count_d = count_q;
                end else begin
                    rf_wren_d   = 1'b1;
                    rf_addr_d   = cur_addr_q;
                    rf_data_d   = cur_data_q;
                    cur_addr_d  = cur_addr_q + ADDR_W'(1);
                    cur_data_d  = incr_q ? cur_data_q + DATA_W'(1) : cur_data_q;
                    remaining_d = remaining_q - (ADDR_W+1)'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            cur_data_q  <= '0;
            remaining_q <= '0;
            count_q     <= '0;
            incr_q      <= 1'b0;
            rf_addr_q   <= '0;
            rf_data_q   <= '0;
            rf_wren_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_count_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            cur_data_q  <= cur_data_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            incr_q      <= incr_d;
            rf_addr_q   <= rf_addr_d;
            rf_data_q   <= rf_data_d;
            rf_wren_q   <= rf_wren_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_count_q <= rsp_count_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rf_addr   = rf_addr_q;
    assign rf_wren   = rf_wren_q;
    assign rf_data   = {1'b0, rf_data_q};
    assign rsp_valid = rsp_valid_q;
    assign rsp_count = rsp_count_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_rf_cmd_seq.sv
// Directed bench for rf_cmd_seq: table of commands with hand-computed write
// streams and register contents, plus back-pressure and mid-operation reset sequences.
module tb_rf_cmd_seq;

    logic        clk;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [1:0]  cmd_addr;
    logic [2:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_count;
    logic        rsp_err;
    logic [1:0]  rf_addr;
    logic        rf_wren;
    logic [32:0] rf_data;
    logic        busy;

    rf_cmd_seq #(.ADDR_W(2), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_count(rsp_count),
        .rsp_err(rsp_err), .rf_addr(rf_addr), .rf_wren(rf_wren),
        .rf_data(rf_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model plus a log of every write that lands.
    logic [31:0] rf_model [4] = '{default: 32'h0};
    logic [1:0]  log_a [$];
    logic [32:0] log_d [$];

    always @(posedge clk) begin
        if (resetn && rf_wren) begin
            rf_model[rf_addr] <= rf_data[31:0];
            log_a.push_back(rf_addr);
            log_d.push_back(rf_data);
        end
    end

    typedef struct {
        logic [1:0]        op;
        logic [1:0]        addr;
        logic [2:0]        len;
        logic [31:0]       data;
        logic              err;
        logic [2:0]        cnt;
        logic [3:0][1:0]   wa;
        logic [3:0][31:0]  wd;
        logic [3:0][31:0]  rf;
    } vec_t;

    vec_t vecs [8];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            chk("rf_data_msb", 64'(rf_data[32]), 64'd0);
            tick();
            lat++;
        end
        if (!rsp_valid) chk("rsp_timeout", 64'(rsp_valid), 64'd1);
    endtask

    task automatic check_rf(input string tag, input logic [3:0][31:0] exp);
        for (int r = 0; r < 4; r++)
            chk($sformatf("%s_rf%0d", tag, r), 64'(rf_model[r]), 64'(exp[r]));
    endtask

    task automatic run_cmd(input vec_t v, input int idx);
        int lat;
        int base;
        string tag;
        tag = $sformatf("vec%0d", idx);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        base      = log_a.size();
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_addr  = v.addr;
        cmd_len   = v.len;
        cmd_data  = v.data;
        tick();
        cmd_valid = 1'b0;
        wait_rsp(lat);
        chk({tag, "_latency"}, 64'(lat), 64'(v.cnt));
        chk({tag, "_rsp_count"}, 64'(rsp_count), 64'(v.cnt));
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(v.err));
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_nwrites"}, 64'(log_a.size() - base), 64'(v.cnt));
        for (int i = 0; i < int'(v.cnt); i++) begin
            if (base + i < log_a.size()) begin
                chk($sformatf("%s_waddr%0d", tag, i), 64'(log_a[base+i]), 64'(v.wa[i]));
                chk($sformatf("%s_wdata%0d", tag, i), 64'(log_d[base+i]), 64'(v.wd[i]));
            end
        end
        tick();
        chk({tag, "_rsp_dropped"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_ready_again"}, 64'(cmd_ready), 64'd1);
        check_rf(tag, v.rf);
    endtask

    initial begin
        int lat;
        int base;

        // rf fields are {r3,r2,r1,r0}; wa/wd are {w3,w2,w1,w0}.
        vecs[0] = '{2'd0, 2'd2, 3'd0, 32'hDEADBEEF, 1'b0, 3'd1,
                    {2'd0, 2'd0, 2'd0, 2'd2}, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},
                    {32'h0, 32'hDEADBEEF, 32'h0, 32'h0}};
        vecs[1] = '{2'd1, 2'd3, 3'd3, 32'hA5, 1'b0, 3'd3,
                    {2'd0, 2'd1, 2'd0, 2'd3}, {32'h0, 32'hA5, 32'hA5, 32'hA5},
                    {32'hA5, 32'hDEADBEEF, 32'hA5, 32'hA5}};
        vecs[2] = '{2'd3, 2'd0, 3'd4, 32'hFFFFFFFE, 1'b0, 3'd4,
                    {2'd3, 2'd2, 2'd1, 2'd0}, {32'h1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE},
                    {32'h1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE}};
        vecs[3] = '{2'd1, 2'd1, 3'd0, 32'h11, 1'b1, 3'd0,
                    {2'd0, 2'd0, 2'd0, 2'd0}, {32'h0, 32'h0, 32'h0, 32'h0},
                    {32'h1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE}};
        vecs[4] = '{2'd3, 2'd2, 3'd5, 32'h22, 1'b1, 3'd0,
                    {2'd0, 2'd0, 2'd0, 2'd0}, {32'h0, 32'h0, 32'h0, 32'h0},
                    {32'h1, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFE}};
        vecs[5] = '{2'd0, 2'd1, 3'd7, 32'h12345678, 1'b0, 3'd1,
                    {2'd0, 2'd0, 2'd0, 2'd1}, {32'h0, 32'h0, 32'h0, 32'h12345678},
                    {32'h1, 32'h0, 32'h12345678, 32'hFFFFFFFE}};
        vecs[6] = '{2'd1, 2'd1, 3'd4, 32'h5A, 1'b0, 3'd4,
                    {2'd0, 2'd3, 2'd2, 2'd1}, {32'h5A, 32'h5A, 32'h5A, 32'h5A},
                    {32'h5A, 32'h5A, 32'h5A, 32'h5A}};
        // Issued after the CLEAR sequence and the aborted FILL.
        vecs[7] = '{2'd0, 2'd3, 3'd0, 32'hBEEF, 1'b0, 3'd1,
                    {2'd0, 2'd0, 2'd0, 2'd3}, {32'h0, 32'h0, 32'h0, 32'hBEEF},
                    {32'hBEEF, 32'h0, 32'hC3, 32'hC3}};

        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_addr  = 2'd0;
        cmd_len   = 3'd0;
        cmd_data  = 32'h0;
        rsp_ready = 1'b1;
        #12;
        chk("rst_rf_wren", 64'(rf_wren), 64'd0);
        chk("rst_rf_addr", 64'(rf_addr), 64'd0);
        chk("rst_rf_data", 64'(rf_data), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_count", 64'(rsp_count), 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        resetn = 1'b1;
        tick();
        chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        for (int v = 0; v < 7; v++) run_cmd(vecs[v], v);

        // CLEAR under back-pressure, with a second command waiting on cmd_valid.
        base      = log_a.size();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_addr  = 2'd2;
        cmd_len   = 3'd1;
        cmd_data  = 32'hFFFF;
        tick();
        cmd_op   = 2'd0;
        cmd_addr = 2'd3;
        cmd_data = 32'h77;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("clr_cmd_ready_k%0d", k), 64'(cmd_ready), 64'd0);
            if (k < 4) begin
                chk($sformatf("clr_wren_k%0d", k), 64'(rf_wren), 64'd1);
                chk($sformatf("clr_addr_k%0d", k), 64'(rf_addr), 64'(k));
                chk($sformatf("clr_data_k%0d", k), 64'(rf_data), 64'd0);
                chk($sformatf("clr_rsp_k%0d", k), 64'(rsp_valid), 64'd0);
            end else begin
                chk($sformatf("clr_wren_k%0d", k), 64'(rf_wren), 64'd0);
                chk($sformatf("clr_rsp_k%0d", k), 64'(rsp_valid), 64'd1);
                chk($sformatf("clr_count_k%0d", k), 64'(rsp_count), 64'd4);
                chk($sformatf("clr_err_k%0d", k), 64'(rsp_err), 64'd0);
            end
            if (k < 9) tick();
        end
        chk("clr_nwrites", 64'(log_a.size() - base), 64'd4);
        check_rf("clr", {32'h0, 32'h0, 32'h0, 32'h0});
        rsp_ready = 1'b1;
        tick();
        chk("clr_rsp_dropped", 64'(rsp_valid), 64'd0);
        chk("clr_ready_again", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
        chk("clr_2nd_wren", 64'(rf_wren), 64'd1);
        chk("clr_2nd_addr", 64'(rf_addr), 64'd3);
        chk("clr_2nd_data", 64'(rf_data), 64'h77);
        chk("clr_2nd_busy", 64'(busy), 64'd1);
        wait_rsp(lat);
        chk("clr_2nd_count", 64'(rsp_count), 64'd1);
        tick();
        check_rf("clr_2nd", {32'h77, 32'h0, 32'h0, 32'h0});

        // FILL of 4 aborted by reset after its second write.
        base      = log_a.size();
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_addr  = 2'd0;
        cmd_len   = 3'd4;
        cmd_data  = 32'hC3;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        resetn = 1'b0;
        #1;
        chk("abort_wren", 64'(rf_wren), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        tick();
        tick();
        resetn = 1'b1;
        tick();
        chk("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("abort_rsp_valid_after", 64'(rsp_valid), 64'd0);
        chk("abort_nwrites", 64'(log_a.size() - base), 64'd2);
        check_rf("abort", {32'h77, 32'h0, 32'hC3, 32'hC3});

        run_cmd(vecs[7], 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
